inst_fetch_resp: RTL and testbench

- Instruction-side responder for the fetch stage. It takes the fetch stage's ce/pc request and returns a 32-bit instruction with a valid pulse, and it holds off the fetch stage with a stall while a word is fetched.
- Words are assembled from a narrow 8-bit req/ack memory bus as four little-endian beats.
- A one-entry last-word buffer makes repeated fetches of the same pc single-cycle.
- The block sits between the IF stage and the instruction memory bus.

---
 rtl/inst_fetch_resp.sv | 171 +++++++++++++++++
 tb/tb_inst_fetch_resp.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// Fetch-stage instruction responder: assembles 32-bit words from a narrow 8-bit
// req/ack bus (four little-endian beats) and short-circuits repeat fetches via a one-word buffer.
module inst_fetch_resp #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        inst_err,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic {IDLE, FETCH} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] base_q, base_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] tag_q, tag_d;
  logic        tag_vld_q, tag_vld_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        inst_err_q, inst_err_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic        aligned;
  logic        hit;
  logic [1:0]  beat_inc;

  assign aligned  = (pc[1:0] == 2'b00);
  assign hit      = tag_vld_q && (tag_q == pc);
  assign beat_inc = beat_q + 2'd1;

  assign stall = (state_q == FETCH) ||
                 ((state_q == IDLE) && ce && !flush && aligned && !hit);

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign inst_err   = inst_err_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    timer_d      = timer_q;
    base_d       = base_q;
    asm_d        = asm_q;
    tag_d        = tag_q;
    tag_vld_d    = tag_vld_q;
    buf_d        = buf_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    inst_err_d   = inst_err_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (ce && !flush) begin
          if (!aligned) begin
            inst_d       = 32'd0;
            inst_err_d   = 1'b1;
            inst_valid_d = 1'b1;
          end else if (hit) begin
            inst_d       = buf_q;
            inst_err_d   = 1'b0;
            inst_valid_d = 1'b1;
          end else begin
            state_d    = FETCH;
            base_d     = pc;
            beat_d     = 2'd0;
            timer_d    = 8'd0;
            mem_req_d  = 1'b1;
            mem_addr_d = pc;
          end
        end
      end

      FETCH: begin
        // Abort outranks any ack arriving in the same cycle.
        if (flush || !ce) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          beat_d    = 2'd0;
          timer_d   = 8'd0;
        end else if (mem_ack) begin
          timer_d = 8'd0;
          if (beat_q == 2'd3) begin
            inst_d       = {mem_rdata, asm_q};
            buf_d        = {mem_rdata, asm_q};
            tag_d        = base_q;
            tag_vld_d    = 1'b1;
            inst_err_d   = 1'b0;
            inst_valid_d = 1'b1;
            mem_req_d    = 1'b0;
            beat_d       = 2'd0;
            state_d      = IDLE;
          end else begin
            case (beat_q)
              2'd0:    asm_d[7:0]   = mem_rdata;
              2'd1:    asm_d[15:8]  = mem_rdata;
              default: asm_d[23:16] = mem_rdata;
            endcase
            beat_d     = beat_inc;
            mem_addr_d = base_q + {30'd0, beat_inc};
          end
        end else if (timer_q == TMO_LAST) begin
          inst_d       = 32'd0;
          inst_err_d   = 1'b1;
          inst_valid_d = 1'b1;
          tag_vld_d    = 1'b0;
          mem_req_d    = 1'b0;
          beat_d       = 2'd0;
          timer_d      = 8'd0;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      timer_q      <= 8'd0;
      base_q       <= 32'd0;
      asm_q        <= 24'd0;
      tag_q        <= 32'd0;
      tag_vld_q    <= 1'b0;
      buf_q        <= 32'd0;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      inst_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      timer_q      <= timer_d;
      base_q       <= base_d;
      asm_q        <= asm_d;
      tag_q        <= tag_d;
      tag_vld_q    <= tag_vld_d;
      buf_q        <= buf_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_err_q   <= inst_err_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp: expected pulses are queued with their
// due cycle when a request is driven and matched when inst_valid appears.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_err;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  inst_fetch_resp #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .inst_err(inst_err), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        ack_en  = 1'b1;
  logic [31:0] tag_m;
  logic        tag_vld_m = 1'b0;
  logic [31:0] buf_m;
  logic [31:0] last_inst = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h78;
      32'h101: return 8'h56;
      32'h102: return 8'h34;
      32'h103: return 8'h12;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic push_exp(input logic [31:0] i, input logic e, input int c);
    exp_t x;
    x.inst = i;
    x.err  = e;
    x.cyc  = c;
    sb.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks any outstanding request in the same cycle when enabled.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (ack_en && mem_req && rst) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_byte(mem_addr);
        addr_log.push_back(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    if (inst_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, inst_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("inst", inst, e.inst);
        chk("inst_err", {31'd0, inst_err}, {31'd0, e.err});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic fetch_miss(input logic [31:0] a);
    int n;
    logic [31:0] w;
    w = exp_word(a);
    addr_log.delete();
    ce = 1'b1;
    pc = a;
    n  = cyc;
    push_exp(w, 1'b0, n + 5);
    #1 chk("miss_stall", {31'd0, stall}, 32'd1);
    tick;
    chk("miss_req", {31'd0, mem_req}, 32'd1);
    chk("miss_addr0", mem_addr, a);
    repeat (4) tick;
    chk("done_req", {31'd0, mem_req}, 32'd0);
    push_exp(w, 1'b0, n + 6);
    #1 chk("rehit_stall", {31'd0, stall}, 32'd0);
    tag_m = a; tag_vld_m = 1'b1; buf_m = w; last_inst = w;
    tick;
    ce = 1'b0;
    chk("rehit_req", {31'd0, mem_req}, 32'd0);
    chk("beat_count", addr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (addr_log.size() > i) chk("beat_addr", addr_log[i], a + 32'(i));
    tick;
  endtask

  task automatic do_hit(input logic [31:0] a);
    ce = 1'b1;
    pc = a;
    push_exp(buf_m, 1'b0, cyc + 1);
    #1 chk("hit_stall", {31'd0, stall}, 32'd0);
    tick;
    ce = 1'b0;
    chk("hit_req", {31'd0, mem_req}, 32'd0);
    last_inst = buf_m;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; ce = 1'b1; pc = 32'h40; flush = 1'b0;
    repeat (3) tick;
    chk("rst_inst", inst, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_err", {31'd0, inst_err}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst = 1'b1;
    #1 chk("post_rst_stall", {31'd0, stall}, 32'd1);
    ce = 1'b0;
    tick;
    chk("idle_no_req", {31'd0, mem_req}, 32'd0);

    fetch_miss(32'h100);
    do_hit(32'h100);

    ce = 1'b1; flush = 1'b1; pc = 32'h180;
    #1 chk("idle_flush_stall", {31'd0, stall}, 32'd0);
    tick;
    chk("idle_flush_req", {31'd0, mem_req}, 32'd0);
    ce = 1'b0; flush = 1'b0;
    tick;

    fetch_miss(32'h104);

    ce = 1'b1; pc = 32'h102;
    push_exp(32'd0, 1'b1, cyc + 1);
    #1 chk("mis_stall", {31'd0, stall}, 32'd0);
    tick;
    ce = 1'b0;
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    last_inst = 32'd0;
    tick;
    do_hit(32'h104);

    ack_en = 1'b0;
    ce = 1'b1; pc = 32'h200;
    n = cyc;
    push_exp(32'd0, 1'b1, n + 9);
    tick;
    chk("tmo_req_rise", {31'd0, mem_req}, 32'd1);
    repeat (7) tick;
    chk("tmo_req_held", {31'd0, mem_req}, 32'd1);
    tick;
    chk("tmo_req_drop", {31'd0, mem_req}, 32'd0);
    #1 chk("tmo_refetch_stall", {31'd0, stall}, 32'd1);
    ce = 1'b0; ack_en = 1'b1;
    tag_vld_m = 1'b0; last_inst = 32'd0;
    tick;
    fetch_miss(32'h200);

    addr_log.delete();
    ce = 1'b1; pc = 32'h300;
    #1 chk("flush_stall", {31'd0, stall}, 32'd1);
    repeat (3) tick;
    flush = 1'b1;
    tick;
    chk("flush_req", {31'd0, mem_req}, 32'd0);
    chk("flush_inst_hold", inst, last_inst);
    chk("flush_no_pulse", {31'd0, inst_valid}, 32'd0);
    chk("flush_beats", addr_log.size(), 32'd3);
    flush = 1'b0; ce = 1'b0;
    tick;
    fetch_miss(32'h300);

    ack_en = 1'b0;
    ce = 1'b1; pc = 32'h500;
    tick;
    chk("arst_req_before", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_inst", inst, 32'd0);
    ce = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick;
    chk("arst_idle_req", {31'd0, mem_req}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
